// File: rtl/cu_pkg.sv
// cu_pkg: shared constants for the ID/EX control unit.
//   - instruction mode encodings (MODE_*)
//   - data-processing opcode encodings (OP_*)
//   - ALU command encodings driven on exe_cmd (EXE_*)
//   - FSM state encoding for the memory-hold sequencer (state_t)
package cu_pkg;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_ILL = 4'b1111;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/cu_decode.sv
// cu_decode: purely combinational decode of mode/opcode/s into control fields.
// Ports:
//   mode, opcode, s       in   instruction fields
//   exe_cmd               out  ALU command
//   mem_read, mem_write,
//   wb_en, b,
//   status_update         out  raw enables (not yet squashed by valid/cond)
//   illegal               out  undefined data-processing opcode or reserved mode
module cu_decode
  import cu_pkg::*;
(
  input  logic [1:0] mode,
  input  logic [3:0] opcode,
  input  logic       s,
  output logic [3:0] exe_cmd,
  output logic       mem_read,
  output logic       mem_write,
  output logic       wb_en,
  output logic       b,
  output logic       status_update,
  output logic       illegal
);

  always_comb begin
    exe_cmd       = EXE_NOP;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    wb_en         = 1'b0;
    b             = 1'b0;
    status_update = 1'b0;
    illegal       = 1'b0;
    case (mode)
      MODE_DP: begin
        wb_en = 1'b1;
        case (opcode)
          OP_MOV: exe_cmd = EXE_MOV;
          OP_MVN: exe_cmd = EXE_MVN;
          OP_ADD: exe_cmd = EXE_ADD;
          OP_ADC: exe_cmd = EXE_ADC;
          OP_SUB: exe_cmd = EXE_SUB;
          OP_SBC: exe_cmd = EXE_SBC;
          OP_AND: exe_cmd = EXE_AND;
          OP_ORR: exe_cmd = EXE_ORR;
          OP_EOR: exe_cmd = EXE_EOR;
          // Compare/test only update flags, never write back.
          OP_CMP: begin
            exe_cmd = EXE_SUB;
            wb_en   = 1'b0;
          end
          OP_TST: begin
            exe_cmd = EXE_AND;
            wb_en   = 1'b0;
          end
          default: begin
            exe_cmd = EXE_ILL;
            wb_en   = 1'b0;
            illegal = 1'b1;
          end
        endcase
        status_update = s & ~illegal;
      end
      MODE_MEM: begin
        exe_cmd   = EXE_ADD;
        mem_read  = s;
        mem_write = ~s;
        wb_en     = s;
      end
      MODE_BR: begin
        exe_cmd = EXE_NOP;
        b       = 1'b1;
      end
      default: begin
        exe_cmd = EXE_ILL;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/control_unit_pipe.sv
// control_unit_pipe: registered ID/EX control unit.
// Decodes the instruction (via cu_decode), squashes enables for invalid,
// condition-failed or illegal instructions, and registers the result.
// Memory ops are held in the output register for MEM_WAIT extra cycles.
// Parameters:
//   MEM_WAIT  extra hold cycles for LDR/STR (0..15)
//   CNT_W     wait counter width, 2^CNT_W > MEM_WAIT
// Ports:
//   clk, rst                    clock, async active-high reset
//   valid_in, mode, opcode, s   instruction inputs
//   cond_pass                   condition check result
//   stall                       freeze output register and counter
//   flush                       load a bubble into the output register
//   exe_cmd, mem_read, mem_write, wb_en, b, status_update, illegal,
//   valid_out                   registered ID/EX control fields
//   busy                        high while holding a memory op (WAIT)
module control_unit_pipe
  import cu_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_in,
  input  logic [1:0] mode,
  input  logic [3:0] opcode,
  input  logic       s,
  input  logic       cond_pass,
  input  logic       stall,
  input  logic       flush,
  output logic [3:0] exe_cmd,
  output logic       mem_read,
  output logic       mem_write,
  output logic       wb_en,
  output logic       b,
  output logic       status_update,
  output logic       illegal,
  output logic       valid_out,
  output logic       busy
);

  logic [3:0] dec_exe_cmd;
  logic       dec_mem_read;
  logic       dec_mem_write;
  logic       dec_wb_en;
  logic       dec_b;
  logic       dec_status_update;
  logic       dec_illegal;

  cu_decode u_decode (
    .mode          (mode),
    .opcode        (opcode),
    .s             (s),
    .exe_cmd       (dec_exe_cmd),
    .mem_read      (dec_mem_read),
    .mem_write     (dec_mem_write),
    .wb_en         (dec_wb_en),
    .b             (dec_b),
    .status_update (dec_status_update),
    .illegal       (dec_illegal)
  );

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic live;
  logic en_ok;
  logic mem_op;

  // A live instruction still reaches the output when illegal (so the trap
  // logic sees it), but with every enable forced off.
  assign live   = valid_in & cond_pass;
  assign en_ok  = live & ~dec_illegal;
  assign mem_op = en_ok & (dec_mem_read | dec_mem_write);

  assign busy = (state == WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      exe_cmd       <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      wb_en         <= 1'b0;
      b             <= 1'b0;
      status_update <= 1'b0;
      illegal       <= 1'b0;
      valid_out     <= 1'b0;
    end else if (flush) begin
      state         <= IDLE;
      cnt           <= '0;
      exe_cmd       <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      wb_en         <= 1'b0;
      b             <= 1'b0;
      status_update <= 1'b0;
      illegal       <= 1'b0;
      valid_out     <= 1'b0;
    end else if (!stall) begin
      case (state)
        IDLE: begin
          exe_cmd       <= dec_exe_cmd;
          mem_read      <= dec_mem_read & en_ok;
          mem_write     <= dec_mem_write & en_ok;
          wb_en         <= dec_wb_en & en_ok;
          b             <= dec_b & en_ok;
          status_update <= dec_status_update & en_ok;
          illegal       <= dec_illegal & live;
          valid_out     <= live;
          if ((MEM_WAIT != 0) && mem_op) begin
            state <= WAIT;
            cnt   <= CNT_W'(MEM_WAIT);
          end
        end
        WAIT: begin
          // Output register holds; leave once the cnt==1 cycle is consumed.
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit_pipe.sv
module tb_control_unit_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_in;
  logic [1:0] mode;
  logic [3:0] opcode;
  logic       s;
  logic       cond_pass;
  logic       stall;
  logic       flush;
  logic [3:0] exe_cmd;
  logic       mem_read, mem_write, wb_en, b, status_update, illegal, valid_out, busy;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  control_unit_pipe #(.MEM_WAIT(3), .CNT_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_in      (valid_in),
    .mode          (mode),
    .opcode        (opcode),
    .s             (s),
    .cond_pass     (cond_pass),
    .stall         (stall),
    .flush         (flush),
    .exe_cmd       (exe_cmd),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .wb_en         (wb_en),
    .b             (b),
    .status_update (status_update),
    .illegal       (illegal),
    .valid_out     (valid_out),
    .busy          (busy)
  );

  // Observed vector: {exe_cmd, mem_read, mem_write, wb_en, b, status_update, illegal, valid_out, busy}
  logic [11:0] obs;
  assign obs = {exe_cmd, mem_read, mem_write, wb_en, b, status_update, illegal, valid_out, busy};

  function automatic logic [11:0] pk(input logic [3:0] e, input logic mr, input logic mw,
                                     input logic wb, input logic bb, input logic su,
                                     input logic il, input logic vo, input logic bz);
    return {e, mr, mw, wb, bb, su, il, vo, bz};
  endfunction

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [3:0] op,
                       input logic ss, input logic cp);
    valid_in = v; mode = m; opcode = op; s = ss; cond_pass = cp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [11:0] ZERO = 12'b0;
  logic [11:0] e_add, e_ldr, e_mov;

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0);
    tick(); tick();
    chk("reset", obs, ZERO);
    rst = 1'b0;

    e_add = pk(4'b0010, 0, 0, 1, 0, 1, 0, 1, 0);
    e_ldr = pk(4'b0010, 1, 0, 1, 0, 0, 0, 1, 1);
    e_mov = pk(4'b0001, 0, 0, 1, 0, 0, 0, 1, 0);

    // ADD s=1
    drive(1, 2'b00, 4'b0100, 1, 1); tick();
    chk("add", obs, e_add);
    // CMP s=1
    drive(1, 2'b00, 4'b1010, 1, 1); tick();
    chk("cmp", obs, pk(4'b0100, 0, 0, 0, 0, 1, 0, 1, 0));
    // CMP with cond_pass=0: enables, illegal, valid_out all 0
    drive(1, 2'b00, 4'b1010, 1, 0); tick();
    chk("cmp_cond_fail", {4'b0, obs[7:0]}, ZERO);
    // valid_in=0 -> bubble enables
    drive(0, 2'b00, 4'b0100, 1, 1); tick();
    chk("not_valid", {4'b0, obs[7:0]}, ZERO);
    // MOV s=0, EOR s=0, TST s=1, branch
    drive(1, 2'b00, 4'b1101, 0, 1); tick();
    chk("mov", obs, e_mov);
    drive(1, 2'b00, 4'b0001, 0, 1); tick();
    chk("eor", obs, pk(4'b1000, 0, 0, 1, 0, 0, 0, 1, 0));
    drive(1, 2'b00, 4'b1000, 1, 1); tick();
    chk("tst", obs, pk(4'b0110, 0, 0, 0, 0, 1, 0, 1, 0));
    drive(1, 2'b10, 4'b0000, 0, 1); tick();
    chk("branch", obs, pk(4'b0000, 0, 0, 0, 1, 0, 0, 1, 0));
    // Undefined opcode and reserved mode
    drive(1, 2'b00, 4'b0111, 1, 1); tick();
    chk("undef_op", obs, pk(4'b1111, 0, 0, 0, 0, 0, 1, 1, 0));
    drive(1, 2'b11, 4'b0100, 1, 1); tick();
    chk("mode11", obs, pk(4'b1111, 0, 0, 0, 0, 0, 1, 1, 0));

    // LDR with MEM_WAIT=3: busy 3 cycles, held 4 cycles, next on 5th edge
    drive(1, 2'b01, 4'b0000, 1, 1); tick();
    chk("ldr_e1", obs, e_ldr);
    drive(1, 2'b00, 4'b1101, 0, 1);
    tick(); chk("ldr_e2", obs, e_ldr);
    tick(); chk("ldr_e3", obs, e_ldr);
    tick(); chk("ldr_e4", obs, {e_ldr[11:1], 1'b0});
    tick(); chk("after_ldr_e5", obs, e_mov);

    // LDR with 2-cycle stall in WAIT: held 6 cycles
    drive(1, 2'b01, 4'b0000, 1, 1); tick();
    chk("ldrs_e1", obs, e_ldr);
    drive(1, 2'b00, 4'b1101, 0, 1);
    stall = 1'b1;
    tick(); chk("ldrs_e2", obs, e_ldr);
    tick(); chk("ldrs_e3", obs, e_ldr);
    stall = 1'b0;
    tick(); chk("ldrs_e4", obs, e_ldr);
    tick(); chk("ldrs_e5", obs, e_ldr);
    tick(); chk("ldrs_e6", obs, {e_ldr[11:1], 1'b0});
    tick(); chk("after_ldrs_e7", obs, e_mov);

    // STR then flush during WAIT
    drive(1, 2'b01, 4'b0011, 0, 1); tick();
    chk("str", obs, pk(4'b0010, 0, 1, 0, 0, 0, 0, 1, 1));
    flush = 1'b1; tick();
    chk("flush_wait", obs, ZERO);
    flush = 1'b0;
    drive(1, 2'b00, 4'b0100, 1, 1); tick();
    chk("add_after_flush", obs, e_add);

    // Stall in IDLE holds the register and ignores inputs
    stall = 1'b1;
    drive(1, 2'b00, 4'b1101, 0, 1); tick();
    chk("stall_hold", obs, e_add);
    // stall + flush together: flush wins
    flush = 1'b1; tick();
    chk("stall_flush", obs, ZERO);
    stall = 1'b0; flush = 1'b0;

    // Async reset mid-WAIT
    drive(1, 2'b01, 4'b0000, 1, 1); tick();
    chk("ldr_pre_rst", obs, e_ldr);
    #2 rst = 1'b1;
    #1 chk("async_rst", obs, ZERO);
    tick();
    rst = 1'b0;
    drive(1, 2'b00, 4'b0100, 1, 1); tick();
    chk("add_after_rst", obs, e_add);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
